accel_argmax: RTL and testbench
===============================

// Module: accel_argmax
// PURPOSE
//  Downstream stage of accel_dot: consumes the fp32 result-vector AXI4-Stream
//  and reduces each vector to its arg-max (classifier decision).
//  Emits a 2-word result packet per input vector:
//   - word0 = index of the maximum element
//   - word1 = fp32 bits of that maximum
//  Sits between the dot-product engine and the DMA write-back stream.
// PARAMETERS
//  VEC_LEN  4  elements per input vector (>=2); must equal accel_dot output rows
//  IDX_W    $clog2(VEC_LEN)  localparam, width of index/counter
// PORTS
//  clk                 in   1   single clock, all logic posedge
//  rst                 in   1   reset; asynchronous, active-low
//  INPUT_AXIS_TDATA    in   32  fp32 element
//  INPUT_AXIS_TLAST    in   1   last element of vector
//  INPUT_AXIS_TVALID   in   1   element valid
//  INPUT_AXIS_TREADY   out  1   block accepts element
//  OUTPUT_AXIS_TDATA   out  32  result word
//  OUTPUT_AXIS_TLAST   out  1   high on word1 (max value)
//  OUTPUT_AXIS_TVALID  out  1   result word valid
//  OUTPUT_AXIS_TREADY  in   1   consumer ready
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst=0, any time incl. mid-vector or mid-packet):
//   - state=ACCUM; count, best_idx, best_val, err all 0
//   - OUTPUT_AXIS_TVALID=0, TLAST=0, TDATA=0; INPUT_AXIS_TREADY=0 while rst=0
//   - partial vector discarded
//  FSM ACCUM -> EMIT_IDX -> EMIT_VAL -> ACCUM.
//  ACCUM:
//   - INPUT_AXIS_TREADY=1; element taken on TVALID&TREADY at posedge
//   - element 0 loads best unconditionally
//   - later elements replace best only if key(x) > key(best), strict
//     => ties keep the lowest index
//   - vector ends on TLAST, or when count reaches VEC_LEN-1 handshake,
//     whichever comes first
//   - err=1 if the end condition is not exactly "TLAST at element VEC_LEN-1"
//     (early TLAST or missing TLAST); on missing TLAST the next element
//     starts a new vector
//  EMIT_IDX:
//   - INPUT_AXIS_TREADY=0
//   - TDATA = {err, 31'(best_idx)}, TLAST=0, TVALID=1
//   - advance on OUTPUT handshake
//  EMIT_VAL:
//   - TDATA=best_val, TLAST=1, TVALID=1
//   - on handshake -> ACCUM, count/err cleared
//  Outputs registered; TDATA/TLAST/TVALID stable while TVALID&!TREADY.
//  Latency: last-element handshake at edge k -> word0 valid after edge k;
//   with TREADY held 1, word1 after k+1; next input accepted after k+2.
//   Throughput = VEC_LEN+2 cycles per vector.
//  Ordering key, 32-bit unsigned compare:
//   - key(x) = x[31] ? ~x : x ^ 32'h8000_0000
//   - total order: -0.0 < +0.0; +NaN largest, -NaN smallest
//   - no FP unit used
// STRUCTURE
//  Package accel_pkg:
//   - typedef logic [31:0] fp32_t
//   - enum argmax_state_t {ACCUM, EMIT_IDX, EMIT_VAL}
//   - function fp32_key(fp32_t) returns the ordering key
//   - ERR_BIT = 31
//  No sub-module; single always_ff FSM + datapath, compare via fp32_key.
// TESTING
//  - Reset held 20 cycles; all outputs 0, INPUT_AXIS_TREADY=0.
//  - Baseline: send 3.8000002, 4.4, 5.0, 5.6000004 (TLAST on 4th)
//    -> 32'h0000_0003, then 32'h40B3_3334 with TLAST.
//  - Negatives: send -1.0, -0.5, -2.0, -3.0
//    -> 32'h0000_0001, then 32'hBF00_0000.
//  - Ties and zero ordering:
//    - 2.0, 7.0, 7.0, 1.0 -> index 1, value 32'h40E0_0000
//    - -0.0, +0.0, -0.0, -0.0 -> index 1, value 32'h0000_0000
//  - Framing error: 1.0, 9.0 with TLAST on 2nd
//    -> 32'h8000_0001, then 32'h4110_0000.
//    A following correct vector gets no err flag.
//  - Backpressure: OUTPUT_AXIS_TREADY=0 for 5 cycles during EMIT_IDX
//    -> word0 held stable, INPUT_AXIS_TREADY=0; release -> both words delivered.
//    Then assert rst mid-vector after 2 elements
//    -> outputs 0; next full vector yields its correct result.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types and the fp32 total-order key used by the arg-max reducer.
package accel_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    EMIT_IDX = 2'd1,
    EMIT_VAL = 2'd2
  } argmax_state_t;

  localparam int ERR_BIT = 31;

  // Maps fp32 bit patterns onto unsigned integers whose order matches the
  // float order: -NaN < -inf < ... < -0.0 < +0.0 < ... < +inf < +NaN.
  function automatic logic [31:0] fp32_key(input fp32_t x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/accel_argmax.sv
// Reduces each fp32 input vector to {err, index} and the max value,
// emitted as a two-word AXI4-Stream packet.
module accel_argmax
  import accel_pkg::*;
#(
  parameter int VEC_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] INPUT_AXIS_TDATA,
  input  logic        INPUT_AXIS_TLAST,
  input  logic        INPUT_AXIS_TVALID,
  output logic        INPUT_AXIS_TREADY,
  output logic [31:0] OUTPUT_AXIS_TDATA,
  output logic        OUTPUT_AXIS_TLAST,
  output logic        OUTPUT_AXIS_TVALID,
  input  logic        OUTPUT_AXIS_TREADY
);

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(VEC_LEN - 1);

  argmax_state_t    state;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] best_idx;
  fp32_t            best_val;
  logic             err;

  logic             in_hs, out_hs;
  logic             take, at_last, vec_end, vec_err;
  logic [IDX_W-1:0] nxt_idx;
  fp32_t            nxt_val;
  logic [31:0]      idx_word;

  assign INPUT_AXIS_TREADY = rst && (state == ACCUM);
  assign in_hs  = INPUT_AXIS_TVALID && INPUT_AXIS_TREADY;
  assign out_hs = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;

  // Strict compare keeps the lowest index on ties; element 0 always loads.
  always_comb begin
    take     = (count == '0) || (fp32_key(INPUT_AXIS_TDATA) > fp32_key(best_val));
    nxt_idx  = take ? count : best_idx;
    nxt_val  = take ? INPUT_AXIS_TDATA : best_val;
    at_last  = (count == LAST_CNT);
    vec_end  = INPUT_AXIS_TLAST || at_last;
    vec_err  = !(INPUT_AXIS_TLAST && at_last);
    idx_word = '0;
    idx_word[IDX_W-1:0] = nxt_idx;
    idx_word[ERR_BIT]   = vec_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ACCUM;
      count              <= '0;
      best_idx           <= '0;
      best_val           <= '0;
      err                <= 1'b0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_hs) begin
            best_idx <= nxt_idx;
            best_val <= nxt_val;
            if (vec_end) begin
              // Word0 goes out on the same edge that takes the last element.
              state              <= EMIT_IDX;
              err                <= vec_err;
              count              <= '0;
              OUTPUT_AXIS_TDATA  <= idx_word;
              OUTPUT_AXIS_TLAST  <= 1'b0;
              OUTPUT_AXIS_TVALID <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        EMIT_IDX: begin
          if (out_hs) begin
            state             <= EMIT_VAL;
            OUTPUT_AXIS_TDATA <= best_val;
            OUTPUT_AXIS_TLAST <= 1'b1;
          end
        end
        EMIT_VAL: begin
          if (out_hs) begin
            state              <= ACCUM;
            count              <= '0;
            err                <= 1'b0;
            OUTPUT_AXIS_TDATA  <= '0;
            OUTPUT_AXIS_TLAST  <= 1'b0;
            OUTPUT_AXIS_TVALID <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_argmax.sv
// Scoreboard bench for accel_argmax: directed vectors, decoupled monitor.
module tb_accel_argmax;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  accel_argmax #(.VEC_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .INPUT_AXIS_TDATA(in_data), .INPUT_AXIS_TLAST(in_last),
    .INPUT_AXIS_TVALID(in_valid), .INPUT_AXIS_TREADY(in_ready),
    .OUTPUT_AXIS_TDATA(out_data), .OUTPUT_AXIS_TLAST(out_last),
    .OUTPUT_AXIS_TVALID(out_valid), .OUTPUT_AXIS_TREADY(out_ready)
  );

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expected word per output handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h last=%b expected none", out_data, out_last);
      end else begin
        chk(name_q.pop_front(), {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic expect_pkt(input string nm, input logic [31:0] w0, input logic [31:0] w1);
    exp_q.push_back({1'b0, w0}); name_q.push_back({nm, "_w0"});
    exp_q.push_back({1'b1, w1}); name_q.push_back({nm, "_w1"});
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic vec4(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d,
                      input logic [31:0] w0, input logic [31:0] w1);
    expect_pkt(nm, w0, w1);
    send(a, 1'b0); send(b, 1'b0); send(c, 1'b0); send(d, 1'b1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete(); name_q.delete();
    end
  endtask

  initial begin
    // Reset held 20 cycles, outputs checked throughout.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2 || i == 19) begin
        chk("reset_tdata", {1'b0, out_data}, 33'h0);
        chk("reset_tlast_tvalid", {31'h0, out_last, out_valid}, 33'h0);
        chk("reset_in_ready", {32'h0, in_ready}, 33'h0);
      end
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    vec4("baseline", 32'h4073_3334, 32'h408C_CCCD, 32'h40A0_0000, 32'h40B3_3334,
         32'h0000_0003, 32'h40B3_3334);
    drain("baseline");
    vec4("negatives", 32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'hC040_0000,
         32'h0000_0001, 32'hBF00_0000);
    drain("negatives");
    vec4("tie", 32'h4000_0000, 32'h40E0_0000, 32'h40E0_0000, 32'h3F80_0000,
         32'h0000_0001, 32'h40E0_0000);
    vec4("zeros", 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000,
         32'h0000_0001, 32'h0000_0000);
    vec4("nan", 32'h3F80_0000, 32'h7FC0_0000, 32'hFFC0_0000, 32'h4000_0000,
         32'h0000_0001, 32'h7FC0_0000);
    drain("order");

    // Early TLAST, then a clean vector must not carry err.
    expect_pkt("early_tlast", 32'h8000_0001, 32'h4110_0000);
    send(32'h3F80_0000, 1'b0); send(32'h4110_0000, 1'b1);
    vec4("after_err", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
         32'h0000_0002, 32'h4040_0000);
    drain("framing");

    // Missing TLAST: 4 elements close the vector, the 5th is a new vector.
    expect_pkt("no_tlast", 32'h8000_0002, 32'h4040_0000);
    send(32'h3F80_0000, 1'b0); send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b0); send(32'h3F00_0000, 1'b0);
    expect_pkt("lone_tlast", 32'h8000_0000, 32'h4110_0000);
    send(32'h4110_0000, 1'b1);
    drain("missing");

    // Backpressure: word0 must hold while the consumer stalls.
    out_ready = 1'b0;
    vec4("bp", 32'hC000_0000, 32'h3F80_0000, 32'h4110_0000, 32'h4000_0000,
         32'h0000_0002, 32'h4110_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_word0", {out_last, out_data}, {1'b0, 32'h0000_0002});
      chk("bp_valid_inready", {31'h0, out_valid, in_ready}, 33'h2);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    drain("bp");

    // Reset mid-vector discards the partial vector.
    send(32'h4110_0000, 1'b0); send(32'h4000_0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {out_last, out_data}, 33'h0);
    chk("midrst_valid_inready", {31'h0, out_valid, in_ready}, 33'h0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    vec4("post_rst", 32'h3F80_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h4040_0000,
         32'h0000_0003, 32'h4040_0000);
    drain("post_rst");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
